usr_serial_ctrl: RTL
====================

Name: usr_serial_ctrl

Overview:
Sequencer that sits directly upstream of the 8-bit universal shift register (USR8) and drives its select, pin, lin and rin inputs.
- Accepts a parallel word over a valid/ready handshake.
- Commands the USR to load it, then shifts it out serially, LSB-first or MSB-first, while shifting a serial input word in (full duplex).
- Presents the received word with a one-cycle valid pulse.
- A shift-enable input paces the bit rate, so the pair forms a simple SPI-like serializer/deserializer.

Parameters:
WIDTH, 8, word width; must equal the USR width.
CNT_W, 4, bit-counter width; must satisfy CNT_W >= clog2(WIDTH+1).

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  a new transfer is offered
cmd_ready  output  1  block can accept a transfer; high only in IDLE
cmd_data  input  WIDTH  word to transmit
cmd_dir  input  1  0 = LSB-first (USR shift right); 1 = MSB-first (USR shift left)
shift_en  input  1  bit-rate strobe; a shift happens only in cycles where this is high
abort  input  1  synchronous abort of the current transfer
ser_in  input  1  serial receive bit
ser_out  output  1  serial transmit bit
ser_valid  output  1  ser_out is valid and is consumed this cycle
usr_q  input  WIDTH  USR parallel output (out)
usr_sel  output  2  USR select code
usr_pin  output  WIDTH  USR parallel load data
usr_lin  output  1  USR left-shift serial input (enters bit 0)
usr_rin  output  1  USR right-shift serial input (enters bit WIDTH-1)
rx_data  output  WIDTH  last received word
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  high in LOAD, SHIFT and DONE

Behaviour:
- USR select encoding (fixed): 00 hold; 01 shift right (rin -> bit WIDTH-1, bit i <- bit i+1); 10 shift left (lin -> bit 0, bit i <- bit i-1); 11 parallel load.
- Reset (async, active-high) puts the block in IDLE and forces: usr_sel=00, usr_pin=0, cnt=0, dir_r=0, rx_data=0, rx_valid=0, ser_valid=0, ser_out=0, busy=0. usr_lin=0, usr_rin=0, cmd_ready=1.
- usr_pin is a register loaded from cmd_data on handshake acceptance.
- dir_r latches cmd_dir on handshake acceptance.

States: IDLE, LOAD, SHIFT, DONE.
- IDLE: usr_sel=00. cmd_ready=1. On cmd_valid && cmd_ready: latch cmd_data and cmd_dir; next state LOAD.
- LOAD: usr_sel=11 for exactly one cycle, so the USR captures usr_pin at the end of the cycle. cnt <= 0; next state SHIFT.
- SHIFT, shift_en=1: usr_sel = dir_r ? 10 : 01; ser_valid=1; cnt increments.
  - ser_out = dir_r ? usr_q[WIDTH-1] : usr_q[0], the bit leaving the USR this cycle.
  - ser_in is driven onto usr_lin when dir_r=1, or onto usr_rin when dir_r=0; the unused serial input is 0.
  - When cnt == WIDTH-1 on an enabled shift, next state is DONE.
- SHIFT, shift_en=0: usr_sel=00, ser_valid=0, ser_out=0, cnt holds; the state stays SHIFT indefinitely.
- DONE: usr_sel=00; rx_data <= usr_q; rx_valid=1 for this single cycle; next state IDLE.
- Outside enabled SHIFT cycles: ser_out=0, ser_valid=0, usr_lin=usr_rin=0.
- Latency with shift_en held high: accept at edge 0; LOAD is cycle 1; SHIFT is cycles 2..WIDTH+1; DONE is cycle WIDTH+2; cmd_ready is high again in cycle WIDTH+3.
- Exactly WIDTH enabled shifts occur per transfer; the count never wraps mid-transfer.
- abort, synchronous, any non-IDLE state: next state IDLE and usr_sel=00 that cycle. No rx_valid pulse and rx_data unchanged. Abort has priority over shift_en and over the DONE update. Abort in IDLE has no effect.
- cmd_valid while not IDLE: ignored; cmd_ready=0. cmd_data and cmd_dir are not sampled.
- Reset mid-transfer: immediate return to IDLE with the reset values above. The USR shares the same reset and clears to 0.
- rx_data holds its value until the next DONE.

Test Plan:
- LSB-first TX: cmd_data=8'h1E, cmd_dir=0, shift_en=1, ser_in=0 -> ser_out over the 8 ser_valid cycles = 0,1,1,1,1,0,0,0; rx_data=8'h00; rx_valid pulses once in cycle 10.
- MSB-first TX with loopback (ser_in=ser_out): cmd_data=8'h1E, cmd_dir=1 -> ser_out = 0,0,0,1,1,1,1,0; rx_data=8'h1E.
- RX ordering: ser_in stream 1,0,0,0,0,0,0,0 -> rx_data=8'h80 with cmd_dir=1; rx_data=8'h01 with cmd_dir=0.
- Pacing: shift_en high every 3rd cycle, loopback, cmd_data=8'hA5 -> exactly 8 ser_valid pulses; usr_sel=00 on gap cycles; rx_data=8'hA5.
- Abort/handshake:
  - abort asserted after 3 shifts -> IDLE next cycle, no rx_valid, rx_data keeps its prior value.
  - cmd_valid held during busy -> no second load until cmd_ready.
- Reset mid-SHIFT: assert reset asynchronously between edges -> usr_sel=00, busy=0, rx_valid=0, cmd_ready=1 immediately. A fresh 8'h3C loopback transfer afterwards returns 8'h3C.

Source files
------------

// File: rtl/usr_serial_ctrl_if.sv
// usr_serial_ctrl_if
// Command handshake between a producer of transmit words and usr_serial_ctrl.
//   cmd_valid : producer offers a transfer
//   cmd_ready : controller can accept (idle)
//   cmd_data  : word to transmit
//   cmd_dir   : 0 = LSB-first, 1 = MSB-first
// master modport is the producer side; slave modport is the controller side.
interface usr_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_data,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        input  cmd_dir,
        output cmd_ready
    );
endinterface

// File: rtl/usr_serial_ctrl.sv
// usr_serial_ctrl
// Sequencer for an external 8-bit universal shift register (USR). A word is
// accepted over the cmd handshake, parallel-loaded into the USR, then shifted
// out one bit per shift_en strobe while the serial input is shifted in. The
// word left in the USR after WIDTH shifts is published on rx_data with a
// single-cycle rx_valid pulse.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   cmd                 : command handshake (slave side)
//   shift_en            : bit-rate strobe
//   abort               : synchronous abort of the current transfer
//   ser_in / ser_out    : serial receive / transmit bit
//   ser_valid           : ser_out is consumed this cycle
//   usr_q               : USR parallel output
//   usr_sel             : USR mode (00 hold, 01 right, 10 left, 11 load)
//   usr_pin             : USR parallel load data
//   usr_lin / usr_rin   : USR left-shift / right-shift serial inputs
//   rx_data / rx_valid  : last received word and its update strobe
//   busy                : a transfer is in progress
module usr_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    usr_serial_ctrl_if.slave cmd,
    input  logic             shift_en,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic [WIDTH-1:0] usr_q,
    output logic [1:0]       usr_sel,
    output logic [WIDTH-1:0] usr_pin,
    output logic             usr_lin,
    output logic             usr_rin,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] pin_q, pin_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             cmd_ready_w;

    // Next-state and output decode. Every output defaults to its idle value so
    // that abort, gap cycles and reset all present a quiet USR interface.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        pin_d       = pin_q;
        rx_data_d   = rx_data_q;
        usr_sel     = SEL_HOLD;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        usr_lin     = 1'b0;
        usr_rin     = 1'b0;
        rx_valid    = 1'b0;
        busy        = 1'b1;
        cmd_ready_w = 1'b0;

        case (state_q)
            IDLE: begin
                busy        = 1'b0;
                cmd_ready_w = 1'b1;
                if (cmd.cmd_valid) begin
                    pin_d   = cmd.cmd_data;
                    dir_d   = cmd.cmd_dir;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    usr_sel = SEL_LOAD;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (shift_en) begin
                    // MSB-first shifts left so bit WIDTH-1 leaves and ser_in
                    // enters at bit 0; LSB-first is the mirror image.
                    usr_sel   = dir_q ? SEL_LEFT : SEL_RIGHT;
                    ser_valid = 1'b1;
                    ser_out   = dir_q ? usr_q[WIDTH-1] : usr_q[0];
                    usr_lin   = dir_q ? ser_in : 1'b0;
                    usr_rin   = dir_q ? 1'b0 : ser_in;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    rx_data_d = usr_q;
                    rx_valid  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            pin_q     <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pin_q     <= pin_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_w;
    assign usr_pin       = pin_q;
    assign rx_data       = rx_data_q;

endmodule
